map_vga_renderer: RTL

Parametrised VGA map renderer: generates display timing, streams the occupancy map out of the map BRAM read port in raster order, and composes the RGB pixel with a device-position marker. It replaces the fixed 640x480 combinational colour logic and multiply-based read address of the current top level. Timing, BRAM read latency, marker size and colour mode are configurable, and the sync outputs are pipeline-aligned with pixel data.

---
 rtl/map_vga_renderer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/map_vga_renderer.sv
// VGA map renderer: raster timing, incremental map BRAM addressing and pixel composition.
// Optional grid overlay enabled by defining MAP_GRID_EN.
module map_vga_renderer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MARKER_R  = 1,
  parameter int unsigned GRID_STEP = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       marker_x,
  input  logic [10:0]       marker_y,
  input  logic [1:0]        color_mode,
  output logic [ADDR_W-1:0] map_raddr,
  output logic              map_ren,
  input  logic [PIX_W-1:0]  map_data,
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int unsigned CW       = 12;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic signed [CW-1:0] MR = CW'(MARKER_R);
`ifdef MAP_GRID_EN
  localparam bit GRID_EN = 1'b1;
`else
  localparam bit GRID_EN = 1'b0;
`endif

  logic [CW-1:0] hcount, vcount, h_next, v_next;
  logic          running;
  logic          frame_next, active_next, active_cur;
  logic [10:0]   mx_l, my_l;
  logic [1:0]    mode_l;

  // Counters hold at (0,0) for one clock after reset so the first frame starts cleanly.
  always_comb begin
    h_next = hcount;
    v_next = vcount;
    if (running) begin
      if (hcount == CW'(H_TOTAL - 1)) begin
        h_next = '0;
        v_next = (vcount == CW'(V_TOTAL - 1)) ? '0 : vcount + CW'(1);
      end else begin
        h_next = hcount + CW'(1);
      end
    end
    frame_next  = (h_next == '0) && (v_next == '0);
    active_next = (h_next < CW'(H_ACTIVE)) && (v_next < CW'(V_ACTIVE));
    active_cur  = running && (hcount < CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      running     <= 1'b0;
      frame_start <= 1'b0;
      map_ren     <= 1'b0;
      map_raddr   <= '0;
      mx_l        <= '0;
      my_l        <= '0;
      mode_l      <= '0;
    end else begin
      running     <= 1'b1;
      hcount      <= h_next;
      vcount      <= v_next;
      frame_start <= frame_next;
      map_ren     <= active_next;
      if (frame_next) begin
        map_raddr <= '0;
        mx_l      <= marker_x;
        my_l      <= marker_y;
        mode_l    <= color_mode;
      end else if (active_cur) begin
        map_raddr <= map_raddr + ADDR_W'(1);
      end
    end
  end

  logic                 blank_c, hs_c, vs_c, mk_c, gr_c;
  logic signed [CW-1:0] dh, dv;

  // Per-pixel flags in the counter domain.
  always_comb begin
    dh      = $signed(hcount) - $signed({1'b0, mx_l});
    dv      = $signed(vcount) - $signed({1'b0, my_l});
    blank_c = !active_cur;
    hs_c    = !(running && (hcount >= CW'(HS_START)) && (hcount < CW'(HS_END)));
    vs_c    = !(running && (vcount >= CW'(VS_START)) && (vcount < CW'(VS_END)));
    mk_c    = (dh >= -MR) && (dh <= MR) && (dv >= -MR) && (dv <= MR);
    gr_c    = GRID_EN && (((hcount % CW'(GRID_STEP)) == '0) || ((vcount % CW'(GRID_STEP)) == '0));
  end

  logic [RD_LAT-1:0] blank_p, hs_p, vs_p, mk_p, gr_p;

  // Flag delay line matching BRAM read latency; LSB is the newest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_p <= '1;
      hs_p    <= '1;
      vs_p    <= '1;
      mk_p    <= '0;
      gr_p    <= '0;
    end else begin
      blank_p <= RD_LAT'({blank_p, blank_c});
      hs_p    <= RD_LAT'({hs_p, hs_c});
      vs_p    <= RD_LAT'({vs_p, vs_c});
      mk_p    <= RD_LAT'({mk_p, mk_c});
      gr_p    <= RD_LAT'({gr_p, gr_c});
    end
  end

  logic        free_c;
  logic [3:0]  gray_c;
  logic [11:0] map_rgb_c, pix_c;

  always_comb begin
    free_c = (map_data == '0);
    gray_c = ~map_data[PIX_W-1 -: 4];
    case (mode_l)
      2'd1:    map_rgb_c = {gray_c, gray_c, gray_c};
      2'd2:    map_rgb_c = free_c ? 12'h000 : 12'hFFF;
      default: map_rgb_c = free_c ? 12'hFFF : 12'h000;
    endcase
    if (blank_p[RD_LAT-1])                 pix_c = 12'h000;
    else if (mk_p[RD_LAT-1])               pix_c = 12'hF00;
    else if (gr_p[RD_LAT-1] && free_c)     pix_c = 12'h888;
    else                                   pix_c = map_rgb_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb   <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= pix_c;
      hsync <= hs_p[RD_LAT-1];
      vsync <= vs_p[RD_LAT-1];
    end
  end

endmodule
